// File: rtl/multi_ch_timer.sv
// multi_ch_timer: NUM_CH independent programmable timers sharing one config bus.
// Each channel has a shadow config (limit, prescale, mode) that is copied into
// its active config only when a start is accepted. Once running, a channel
// ticks every prescale+1 clocks. After `limit` ticks it raises a one-cycle
// expire pulse and sets its sticky done flag. A one-shot channel then returns
// to IDLE; a periodic channel keeps running with no gap cycle.
// Optional feature: define TIMER_PAUSE_EN to add a per-channel pause input
// that freezes a running channel without leaving RUN.
module multi_ch_timer #(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 16,
  parameter  int PSC_W  = 8,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_limit,
  input  logic [PSC_W-1:0]  cfg_psc,
  input  logic              cfg_mode,
  input  logic [NUM_CH-1:0] start,
  input  logic [NUM_CH-1:0] stop,
  input  logic [NUM_CH-1:0] done_clr,
`ifdef TIMER_PAUSE_EN
  input  logic [NUM_CH-1:0] pause,
`endif
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] expire,
  output logic [NUM_CH-1:0] done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] sh_limit;
    logic [CNT_W-1:0] act_limit;
    logic [CNT_W-1:0] count;
    logic [PSC_W-1:0] sh_psc;
    logic [PSC_W-1:0] act_psc;
    logic [PSC_W-1:0] psc_cnt;
    logic             sh_mode;
    logic             act_mode;
    logic             busy_r;
    logic             expire_r;
    logic             done_r;
    logic             sel;
    logic [CNT_W-1:0] new_limit;
    logic [PSC_W-1:0] new_psc;
    logic             new_mode;
    logic             go;
    logic             hold;
    logic             tick;
    logic             last;

    // An out-of-range cfg_ch never matches any channel, so the write is dropped.
    assign sel = cfg_we && (cfg_ch == CH_W'(i));

    // A write in the same cycle as a start is forwarded so the start latches it.
    assign new_limit = sel ? cfg_limit : sh_limit;
    assign new_psc   = sel ? cfg_psc   : sh_psc;
    assign new_mode  = sel ? cfg_mode  : sh_mode;

    // Stop beats start; a zero limit would never expire, so it is refused.
    assign go = start[i] && !stop[i] && (new_limit != '0);

`ifdef TIMER_PAUSE_EN
    assign hold = pause[i];
`else
    assign hold = 1'b0;
`endif

    assign tick = (psc_cnt == act_psc);
    assign last = (count == act_limit - CNT_W'(1));

    // Shadow configuration register, written from the shared cfg bus.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sh_limit <= '0;
        sh_psc   <= '0;
        sh_mode  <= 1'b0;
      end else if (sel) begin
        sh_limit <= cfg_limit;
        sh_psc   <= cfg_psc;
        sh_mode  <= cfg_mode;
      end
    end

    // Channel FSM with prescaler, tick counter and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state     <= ST_IDLE;
        count     <= '0;
        psc_cnt   <= '0;
        act_limit <= '0;
        act_psc   <= '0;
        act_mode  <= 1'b0;
        busy_r    <= 1'b0;
        expire_r  <= 1'b0;
        done_r    <= 1'b0;
      end else begin
        expire_r <= 1'b0;
        // Cleared first so that an expiry in the same cycle still sets done.
        if (done_clr[i]) begin
          done_r <= 1'b0;
        end
        if (go) begin
          // Start from IDLE or restart from RUN: fresh counters, fresh config.
          state     <= ST_RUN;
          busy_r    <= 1'b1;
          count     <= '0;
          psc_cnt   <= '0;
          act_limit <= new_limit;
          act_psc   <= new_psc;
          act_mode  <= new_mode;
          done_r    <= 1'b0;
        end else begin
          unique case (state)
            ST_IDLE: begin
              busy_r <= 1'b0;
            end
            ST_RUN: begin
              if (stop[i]) begin
                // Abort also swallows an expiry due on this same edge.
                state  <= ST_IDLE;
                busy_r <= 1'b0;
              end else if (!hold) begin
                if (tick) begin
                  psc_cnt <= '0;
                  if (last) begin
                    count    <= '0;
                    expire_r <= 1'b1;
                    done_r   <= 1'b1;
                    if (!act_mode) begin
                      state  <= ST_IDLE;
                      busy_r <= 1'b0;
                    end
                  end else begin
                    count <= count + CNT_W'(1);
                  end
                end else begin
                  psc_cnt <= psc_cnt + PSC_W'(1);
                end
              end
            end
            default: begin
              state  <= ST_IDLE;
              busy_r <= 1'b0;
            end
          endcase
        end
      end
    end

    assign busy[i]   = busy_r;
    assign expire[i] = expire_r;
    assign done[i]   = done_r;
  end

endmodule

// File: tb/tb_multi_ch_timer.sv
// Testbench for multi_ch_timer: table-driven one-shot vectors plus hand-written
// sequences for periodic runs, collisions, restart, reset and pause.
// Expected expire cycles are pushed to a scoreboard queue when a start is
// driven; a negedge monitor compares every channel's expire against it each cycle.
module tb_multi_ch_timer;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int PSC_W  = 8;
  localparam int CH_W   = 2;

  logic              clk;
  logic              rst_n;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_limit;
  logic [PSC_W-1:0]  cfg_psc;
  logic              cfg_mode;
  logic [NUM_CH-1:0] start;
  logic [NUM_CH-1:0] stop;
  logic [NUM_CH-1:0] done_clr;
  logic [NUM_CH-1:0] pause;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] expire;
  logic [NUM_CH-1:0] done;

  multi_ch_timer #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .PSC_W  (PSC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_limit (cfg_limit),
    .cfg_psc   (cfg_psc),
    .cfg_mode  (cfg_mode),
    .start     (start),
    .stop      (stop),
    .done_clr  (done_clr),
`ifdef TIMER_PAUSE_EN
    .pause     (pause),
`endif
    .busy      (busy),
    .expire    (expire),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    int ch;
    int at;
  } ev_t;
  ev_t sbq[$];

  typedef struct {
    int ch;
    int lim;
    int psc;
    int dly;
  } vec_t;
  vec_t vec[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [NUM_CH-1:0] bit_of(input int c);
    logic [NUM_CH-1:0] m;
    m    = '0;
    m[c] = 1'b1;
    return m;
  endfunction

  task automatic push(input int ch, input int at);
    ev_t e;
    e.ch = ch;
    e.at = at;
    sbq.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_cfg(input int ch, input int lim, input int psc, input bit mode);
    cfg_we    = 1'b1;
    cfg_ch    = ch[CH_W-1:0];
    cfg_limit = lim[CNT_W-1:0];
    cfg_psc   = psc[PSC_W-1:0];
    cfg_mode  = mode;
    step();
    cfg_we    = 1'b0;
  endtask

  task automatic pulse_start(input logic [NUM_CH-1:0] m);
    start = m;
    step();
    start = '0;
  endtask

  task automatic pulse_clr(input logic [NUM_CH-1:0] m);
    done_clr = m;
    step();
    done_clr = '0;
  endtask

  // Waits for every queued expiry to come due; bounded by a cycle budget.
  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("scoreboard_drain", sbq.size(), 0);
    sbq.delete();
  endtask

  // Per-cycle expire monitor against the scoreboard.
  always @(negedge clk) begin : mon
    logic e;
    if (mon_en) begin
      for (int c = 0; c < NUM_CH; c++) begin
        e = 1'b0;
        for (int k = sbq.size() - 1; k >= 0; k--) begin
          if (sbq[k].ch == c && sbq[k].at == cyc) begin
            e = 1'b1;
            sbq.delete(k);
          end
        end
        check($sformatf("expire_ch%0d", c), expire[c], e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : test
    int s;
    int s2;
    int s3;
    vec_t v;

    vec[0] = '{ch: 0, lim: 3, psc: 0, dly: 3};
    vec[1] = '{ch: 1, lim: 2, psc: 3, dly: 8};
    vec[2] = '{ch: 2, lim: 1, psc: 0, dly: 1};
    vec[3] = '{ch: 3, lim: 4, psc: 2, dly: 12};
    vec[4] = '{ch: 0, lim: 1, psc: 5, dly: 6};
    vec[5] = '{ch: 1, lim: 7, psc: 1, dly: 14};

    rst_n     = 1'b0;
    cfg_we    = 1'b0;
    cfg_ch    = '0;
    cfg_limit = '0;
    cfg_psc   = '0;
    cfg_mode  = 1'b0;
    start     = '0;
    stop      = '0;
    done_clr  = '0;
    pause     = '0;
    repeat (3) step();
    check("reset_busy", busy, 0);
    check("reset_expire", expire, 0);
    check("reset_done", done, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step();

    // One-shot vectors: busy window, expiry cycle and sticky done.
    for (int k = 0; k < 6; k++) begin
      v = vec[k];
      do_cfg(v.ch, v.lim, v.psc, 1'b0);
      s = cyc + 1;
      push(v.ch, s + v.dly);
      pulse_start(bit_of(v.ch));
      check($sformatf("vec%0d_busy_start", k), busy[v.ch], 1);
      wait_until(s + v.dly - 1);
      check($sformatf("vec%0d_busy_last", k), busy[v.ch], 1);
      check($sformatf("vec%0d_done_before", k), done[v.ch], 0);
      wait_until(s + v.dly);
      check($sformatf("vec%0d_busy_after", k), busy[v.ch], 0);
      check($sformatf("vec%0d_done_after", k), done[v.ch], 1);
      pulse_clr(bit_of(v.ch));
      check($sformatf("vec%0d_done_clr", k), done[v.ch], 0);
    end
    drain(4);

    // Periodic ch1, L=2 P=3: pulses every 8 clocks until stopped.
    do_cfg(1, 2, 3, 1'b1);
    s = cyc + 1;
    push(1, s + 8);
    push(1, s + 16);
    pulse_start(bit_of(1));
    wait_until(s + 8);
    check("periodic_busy_after_expiry", busy[1], 1);
    wait_until(s + 19);
    stop = bit_of(1);
    step();
    stop = '0;
    check("periodic_busy_after_stop", busy[1], 0);
    wait_until(s + 30);
    check("periodic_done_after_stop", done[1], 1);
    drain(4);

    // All channels started together, each with its own period.
    do_cfg(0, 5, 0, 1'b0);
    do_cfg(1, 3, 1, 1'b0);
    do_cfg(2, 2, 3, 1'b0);
    do_cfg(3, 1, 6, 1'b0);
    s = cyc + 1;
    push(0, s + 5);
    push(1, s + 6);
    push(2, s + 8);
    push(3, s + 7);
    pulse_start('1);
    check("multi_busy_all", busy, 4'hf);
    wait_until(s + 6);
    check("multi_busy_mid", busy, 4'b1100);
    drain(20);
    check("multi_done_all", done, 4'hf);
    check("multi_busy_none", busy, 0);

    // start + stop together on ch2: stays idle, done untouched.
    start = bit_of(2);
    stop  = bit_of(2);
    step();
    start = '0;
    stop  = '0;
    check("startstop_busy", busy[2], 0);
    check("startstop_done", done[2], 1);

    // Start with limit 0 on ch3 is refused and leaves done alone.
    do_cfg(3, 0, 0, 1'b0);
    pulse_start(bit_of(3));
    check("zero_limit_busy", busy[3], 0);
    check("zero_limit_done", done[3], 1);

    // done_clr on the expiry cycle: done stays set.
    do_cfg(0, 3, 0, 1'b0);
    s = cyc + 1;
    push(0, s + 3);
    pulse_start(bit_of(0));
    check("start_clears_done", done[0], 0);
    wait_until(s + 2);
    pulse_clr(bit_of(0));
    check("clr_on_expiry_done", done[0], 1);

    // stop on the expiry cycle suppresses the pulse and done.
    do_cfg(1, 2, 0, 1'b0);
    s = cyc + 1;
    pulse_start(bit_of(1));
    wait_until(s + 1);
    stop = bit_of(1);
    step();
    stop = '0;
    check("stop_on_expiry_busy", busy[1], 0);
    check("stop_on_expiry_done", done[1], 0);
    repeat (4) step();
    drain(4);

    // Restart ch0 two clocks into an L=5 run; cfg write mid-run is deferred.
    do_cfg(0, 5, 0, 1'b0);
    s = cyc + 1;
    pulse_start(bit_of(0));
    wait_until(s + 1);
    s2 = cyc + 1;
    push(0, s2 + 5);
    pulse_start(bit_of(0));
    do_cfg(0, 2, 0, 1'b0);
    wait_until(s2 + 4);
    check("restart_busy_old_limit", busy[0], 1);
    drain(10);
    check("restart_done", done[0], 1);
    s3 = cyc + 1;
    push(0, s3 + 2);
    pulse_start(bit_of(0));
    check("restart_start_clears_done", done[0], 0);
    drain(6);

    // cfg write and start on the same cycle: the new limit is used.
    cfg_we    = 1'b1;
    cfg_ch    = 2'd2;
    cfg_limit = 16'd4;
    cfg_psc   = 8'd0;
    cfg_mode  = 1'b0;
    start     = bit_of(2);
    s = cyc + 1;
    push(2, s + 4);
    step();
    cfg_we = 1'b0;
    start  = '0;
    drain(10);
    check("cfg_and_start_done", done[2], 1);

    // Asynchronous reset mid-run: outputs drop at once, no late expire.
    do_cfg(0, 10, 0, 1'b0);
    do_cfg(1, 10, 0, 1'b1);
    pulse_start(4'b0011);
    check("prereset_busy", busy, 4'b0011);
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_busy", busy, 0);
    check("async_reset_done", done, 0);
    check("async_reset_expire", expire, 0);
    step();
    rst_n = 1'b1;
    repeat (15) step();
    check("post_reset_busy", busy, 0);

`ifdef TIMER_PAUSE_EN
    // A 4-cycle pause delays the L=6 expiry by 4 clocks.
    do_cfg(0, 6, 0, 1'b0);
    s = cyc + 1;
    push(0, s + 10);
    pulse_start(bit_of(0));
    wait_until(s + 1);
    pause = bit_of(0);
    repeat (2) step();
    check("pause_busy", busy[0], 1);
    repeat (2) step();
    pause = '0;
    wait_until(s + 9);
    check("pause_busy_late", busy[0], 1);
    drain(6);
    check("pause_done", done[0], 1);
`endif

    drain(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
